seg_scan_capture: RTL and testbench
===================================

SEG_SCAN_CAPTURE -- requirements
Module: seg_scan_capture

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 4, the number of consecutive identical samples (range 2..255) required to accept a digit.
REQ-002 The block SHALL have port i_clk, input, 1, the single system clock; all logic on rising edge.
REQ-003 The block SHALL have port i_rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port i_LED, input, 8, scanned segment bus: bit0..bit6 = a..g, bit7 = dp, active-low.
REQ-005 The block SHALL have port i_digitSelect, input, 4, digit enables, active-low, bit0 = rightmost digit.
REQ-006 The block SHALL have port o_value, output, 16, last complete frame, nibble k = digit k hex value.
REQ-007 The block SHALL have port o_dp, output, 4, last frame decimal points, bit k = digit k dp lit.
REQ-008 The block SHALL have port o_blank, output, 4, last frame blank flags, bit k = digit k had no segment lit.
REQ-009 The block SHALL have port o_frameValid, output, 1, one-cycle pulse when o_value/o_dp/o_blank update.
REQ-010 The block SHALL have port o_patternErr, output, 1, one-cycle pulse on acceptance of an undecodable pattern.
REQ-011 The block SHALL have port o_selectErr, output, 1, one-cycle pulse when a sample has more than one digit enabled.

Function
REQ-012 i_LED and i_digitSelect SHALL be registered once; all decisions use the registered sample (1-cycle input latency).
REQ-013 Decode, on inverted segments (active-high a..g): 3F=0 06=1 5B=2 4F=3 66=4 6D=5 7D=6 07=7 7F=8 6F=9 77=A 7C=b 39=C 5E=d 79=E 71=F; 00 = blank (nibble 0); all else invalid.
REQ-014 FSM states IDLE, TRACK, HOLD: IDLE when no digit enabled.
REQ-015 IDLE->TRACK on a sample with exactly one digit enabled; stability counter loads 1.
REQ-016 TRACK: counter increments while select and i_LED equal the previous sample; any change restarts counter at 1 (new digit) or goes IDLE (no digit).
REQ-017 When counter reaches STABLE_CYCLES, the digit SHALL be accepted on that edge and FSM enters HOLD; counter saturates.
REQ-018 HOLD: no re-acceptance until select or pattern changes; change -> TRACK (counter 1) or IDLE.
REQ-019 Acceptance of a valid/blank pattern SHALL write nibble, dp, blank into shadow registers for that digit and set its bit in a 4-bit captured mask.
REQ-020 Acceptance of an invalid pattern SHALL pulse o_patternErr on the next cycle and SHALL NOT set the mask bit.
REQ-021 Re-acceptance of an already-captured digit before frame completion SHALL overwrite its shadow entry.
REQ-022 The cycle after the mask becomes 4'b1111, o_value/o_dp/o_blank SHALL load from shadow, o_frameValid SHALL pulse for one cycle, and the mask SHALL clear.
REQ-023 A sample with 2+ digits enabled SHALL pulse o_selectErr the next cycle and force FSM to IDLE; no acceptance.
REQ-024 Acceptance and frame completion in the same cycle SHALL both take effect (new acceptance lands in the cleared mask).

Reset
REQ-025 i_rst high SHALL immediately force: FSM IDLE, counter 0, mask 0, shadow 0, o_value 16'h0000, o_dp 0, o_blank 4'hF, all pulses 0, input register to idle (i_LED 8'hFF, select 4'hF).
REQ-026 Reset asserted mid-frame SHALL discard partial captures; first frame after release requires all four digits anew.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the 16 segment code constants, and the blank code.
REQ-028 Segment-to-hex decode SHALL be a sub-module seg7_decode (8-bit pattern in; nibble, dp, blank, valid out), combinational.

Verification
REQ-029 Scan 1,2,3,4 (digit0..3), each held 6 cycles, STABLE_CYCLES=4 -> o_value 16'h4321, o_frameValid one pulse, o_blank 0.
REQ-030 Digit2 shows 8'hFF (blank) with dp 0 -> o_blank 4'b0100, nibble2 = 0 in o_value.
REQ-031 Digit1 held 3 cycles then changed -> not accepted, no frame until digit1 re-held >=4 cycles.
REQ-032 i_digitSelect 4'b0011 for 1 cycle -> o_selectErr pulse, FSM IDLE, no mask change.
REQ-033 Digit0 pattern inverted 0x12 for 5 cycles -> o_patternErr pulse, frame withheld.
REQ-034 i_rst pulsed after digits 0-2 captured -> outputs at reset values, then 4 fresh digits needed for o_frameValid.

Source files
------------

// File: rtl/seg_scan_capture_pkg.sv
// Shared types and constants for the seven-segment scan capture block.
package seg_scan_capture_pkg;

  // Per-digit tracking state of the scanned bus.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  // Active-high segment codes, bit0..bit6 = a..g.
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Digit number of a single active-low enable; only meaningful when exactly one bit is low.
  function automatic logic [1:0] digit_index(input logic [3:0] sel);
    case (sel)
      4'b1101: digit_index = 2'd1;
      4'b1011: digit_index = 2'd2;
      4'b0111: digit_index = 2'd3;
      default: digit_index = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational decode of one active-low segment pattern into hex nibble, dp, blank and valid.
module seg7_decode
  import seg_scan_capture_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] nibble,
  output logic       dp,
  output logic       blank,
  output logic       valid
);

  logic [6:0] seg;

  assign seg   = ~pattern[6:0];
  assign dp    = ~pattern[7];
  assign blank = (seg == SEG_BLANK);

  // Map lit segments to a hex value; anything not in the table is flagged invalid.
  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    nibble = 4'h0;
    valid  = 1'b1;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: nibble = 4'h0;
      default:   valid  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_scan_capture.sv
// Captures a multiplexed 4-digit seven-segment display into a stable hex frame.
module seg_scan_capture
  import seg_scan_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_LED,
  input  logic [3:0]  i_digitSelect,
  output logic [15:0] o_value,
  output logic [3:0]  o_dp,
  output logic [3:0]  o_blank,
  output logic        o_frameValid,
  output logic        o_patternErr,
  output logic        o_selectErr
);

  localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);

  logic [7:0]  led_q, led_p;
  logic [3:0]  sel_q, sel_p;
  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic        accept;
  logic        sel_none, sel_one, sel_multi, same;
  logic [1:0]  idx;
  logic [3:0]  mask_q, mask_d;
  logic        frame_done;
  logic [15:0] value_sh;
  logic [3:0]  dp_sh, blank_sh;
  logic [3:0]  dec_nibble;
  logic        dec_dp, dec_blank, dec_valid;

  assign sel_none   = (sel_q == 4'hF);
  assign sel_one    = sel_q inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
  assign sel_multi  = ~sel_none & ~sel_one;
  assign same       = (sel_q == sel_p) && (led_q == led_p);
  assign idx        = digit_index(sel_q);
  assign frame_done = (mask_q == 4'hF);

  seg7_decode u_decode (
    .pattern (led_q),
    .nibble  (dec_nibble),
    .dp      (dec_dp),
    .blank   (dec_blank),
    .valid   (dec_valid)
  );

  // Register the scanned bus, keeping the previous sample for the stability compare.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      led_q <= 8'hFF;
      sel_q <= 4'hF;
      led_p <= 8'hFF;
      sel_p <= 4'hF;
    end else begin
      // NOTE: non-blocking so led_p takes the old led_q, forming a true two-stage pipe.
      led_q <= i_LED;
      sel_q <= i_digitSelect;
      led_p <= led_q;
      sel_p <= sel_q;
    end
  end

  // Tracking state and stability counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Next-state: count identical single-digit samples and accept once the run hits STABLE_N.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    accept  = 1'b0;
    if (sel_multi || sel_none) begin
      state_d = ST_IDLE;
      count_d = 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_TRACK;
          count_d = 8'd1;
        end
        ST_TRACK: begin
          if (!same) begin
            count_d = 8'd1;
          end else if (count_q + 8'd1 >= STABLE_N) begin
            accept  = 1'b1;
            state_d = ST_HOLD;
            count_d = STABLE_N;
          end else begin
            count_d = count_q + 8'd1;
          end
        end
        ST_HOLD: begin
          if (!same) begin
            state_d = ST_TRACK;
            count_d = 8'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = 8'd0;
        end
      endcase
    end
  end

  // Completed frames clear the mask; an acceptance on the same edge lands in the cleared mask.
  always_comb begin
    mask_d = frame_done ? 4'h0 : mask_q;
    if (accept && dec_valid) mask_d[idx] = 1'b1;
  end

  // Shadow capture, frame publication and error pulses.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: shadow entries are reset so a frame after reset never exposes pre-reset digits.
      value_sh     <= 16'h0000;
      dp_sh        <= 4'h0;
      blank_sh     <= 4'h0;
      mask_q       <= 4'h0;
      o_value      <= 16'h0000;
      o_dp         <= 4'h0;
      o_blank      <= 4'hF;
      o_frameValid <= 1'b0;
      o_patternErr <= 1'b0;
      o_selectErr  <= 1'b0;
    end else begin
      mask_q       <= mask_d;
      o_frameValid <= frame_done;
      o_patternErr <= accept & ~dec_valid;
      o_selectErr  <= sel_multi;
      if (frame_done) begin
        o_value <= value_sh;
        o_dp    <= dp_sh;
        o_blank <= blank_sh;
      end
      if (accept && dec_valid) begin
        value_sh[{idx, 2'b00} +: 4] <= dec_nibble;
        dp_sh[idx]                  <= dec_dp;
        blank_sh[idx]               <= dec_blank;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Scoreboard bench for seg_scan_capture: a run-length reference model predicts frames and error pulses.
module tb_seg_scan_capture;

  localparam int STABLE = 4;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  led = 8'hFF;
  logic [3:0]  sel = 4'hF;
  logic [15:0] o_value;
  logic [3:0]  o_dp, o_blank;
  logic        o_frameValid, o_patternErr, o_selectErr;

  int n_checks = 0;
  int n_errors = 0;

  frame_t exp_q[$];
  int frames_seen = 0;
  int perr_seen = 0, serr_seen = 0;
  int perr_exp = 0, serr_exp = 0;

  // Reference model state: run length of identical single-digit samples and captured digits.
  logic [6:0] seg_tab [16];
  logic [3:0] prev_sel;
  logic [7:0] prev_led;
  int         run;
  logic [3:0] mask;
  logic [3:0] m_nib [4];
  logic       m_dp [4];
  logic       m_blk [4];

  seg_scan_capture #(.STABLE_CYCLES(STABLE)) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_LED         (led),
    .i_digitSelect (sel),
    .o_value       (o_value),
    .o_dp          (o_dp),
    .o_blank       (o_blank),
    .o_frameValid  (o_frameValid),
    .o_patternErr  (o_patternErr),
    .o_selectErr   (o_selectErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // -1 = undecodable, 16 = blank, else the hex value.
  function automatic int model_decode(input logic [7:0] p);
    logic [6:0] s;
    s = ~p[6:0];
    if (s == 7'h00) return 16;
    for (int i = 0; i < 16; i++) if (seg_tab[i] == s) return i;
    return -1;
  endfunction

  task automatic model_reset();
    prev_sel = 4'hF;
    prev_led = 8'hFF;
    run      = 0;
    mask     = 4'h0;
    for (int i = 0; i < 4; i++) begin
      m_nib[i] = 4'h0;
      m_dp[i]  = 1'b0;
      m_blk[i] = 1'b0;
    end
  endtask

  task automatic model_accept(input int k, input logic [7:0] p);
    int d;
    frame_t f;
    d = model_decode(p);
    if (d < 0) begin
      perr_exp++;
      return;
    end
    m_nib[k] = (d == 16) ? 4'h0 : 4'(d);
    m_dp[k]  = ~p[7];
    m_blk[k] = (d == 16);
    mask[k]  = 1'b1;
    if (mask == 4'hF) begin
      for (int i = 0; i < 4; i++) begin
        f.value[i*4 +: 4] = m_nib[i];
        f.dp[i]           = m_dp[i];
        f.blank[i]        = m_blk[i];
      end
      exp_q.push_back(f);
      mask = 4'h0;
    end
  endtask

  task automatic model_step(input logic [3:0] s, input logic [7:0] p);
    int lows;
    int k;
    lows = 0;
    k = 0;
    for (int i = 0; i < 4; i++) if (!s[i]) begin lows++; k = i; end
    if (lows >= 2) begin
      serr_exp++;
      run = 0;
    end else if (lows == 0) begin
      run = 0;
    end else begin
      run = (s == prev_sel && p == prev_led) ? run + 1 : 1;
      if (run == STABLE) model_accept(k, p);
    end
    prev_sel = s;
    prev_led = p;
  endtask

  task automatic drive(input logic [3:0] s, input logic [7:0] p, input int n);
    repeat (n) begin
      @(negedge clk);
      sel = s;
      led = p;
      model_step(s, p);
    end
  endtask

  task automatic digit(input int k, input int v, input logic dp, input int n);
    drive(~(4'b0001 << k), ~{dp, seg_tab[v]}, n);
  endtask

  task automatic idle(input int n);
    drive(4'hF, 8'hFF, n);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    sel = 4'hF;
    led = 8'hFF;
    model_reset();
    @(negedge clk);
    check("rst_value", 32'(o_value), 32'h0);
    check("rst_dp", 32'(o_dp), 32'h0);
    check("rst_blank", 32'(o_blank), 32'hF);
    check("rst_pulses", {29'd0, o_frameValid, o_patternErr, o_selectErr}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: compare each presented frame against the oldest predicted one; count error pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (o_frameValid) begin
        frames_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_frame: got value 0x%0h, expected no frame", o_value);
        end else begin
          frame_t e;
          e = exp_q.pop_front();
          check("frame_value", 32'(o_value), 32'(e.value));
          check("frame_dp", 32'(o_dp), 32'(e.dp));
          check("frame_blank", 32'(o_blank), 32'(e.blank));
        end
      end
      if (o_patternErr) perr_seen++;
      if (o_selectErr) serr_seen++;
    end
  end

  initial begin
    int f0, p0, s0;
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    model_reset();
    do_reset();

    // Basic scan 1,2,3,4.
    digit(0, 1, 1'b0, 6); digit(1, 2, 1'b0, 6); digit(2, 3, 1'b0, 6); digit(3, 4, 1'b0, 6);
    idle(4);
    check("scan_value", 32'(o_value), 32'h4321);
    check("scan_blank", 32'(o_blank), 32'h0);
    check("scan_frames", 32'(frames_seen), 32'd1);

    // Blank digit 2.
    digit(0, 5, 1'b0, 6); digit(1, 6, 1'b0, 6);
    drive(4'b1011, 8'hFF, 6);
    digit(3, 7, 1'b1, 6);
    idle(4);
    check("blank_value", 32'(o_value), 32'h7065);
    check("blank_mask", 32'(o_blank), 32'b0100);
    check("blank_dp", 32'(o_dp), 32'b1000);

    // Digit 1 held too briefly: frame waits for a proper hold.
    f0 = frames_seen;
    digit(0, 9, 1'b0, 6); digit(1, 8, 1'b0, 3); digit(2, 10, 1'b0, 6); digit(3, 11, 1'b0, 6);
    idle(4);
    check("short_no_frame", 32'(frames_seen), 32'(f0));
    digit(1, 8, 1'b0, 4);
    idle(4);
    check("short_then_frame", 32'(frames_seen), 32'(f0 + 1));
    check("short_value", 32'(o_value), 32'hBA89);

    // Two digits enabled for one cycle.
    s0 = serr_seen;
    digit(0, 12, 1'b0, 6);
    drive(4'b0011, 8'h00, 1);
    idle(3);
    check("select_err_pulse", 32'(serr_seen), 32'(s0 + 1));
    digit(1, 13, 1'b0, 6); digit(2, 14, 1'b0, 6); digit(3, 15, 1'b0, 6);
    idle(4);
    check("select_value", 32'(o_value), 32'hFEDC);

    // Undecodable pattern on digit 0 withholds the frame.
    f0 = frames_seen;
    p0 = perr_seen;
    drive(4'b1110, ~8'h12, 5);
    digit(1, 1, 1'b0, 6); digit(2, 2, 1'b0, 6); digit(3, 3, 1'b0, 6);
    idle(4);
    check("pattern_err_pulse", 32'(perr_seen), 32'(p0 + 1));
    check("pattern_no_frame", 32'(frames_seen), 32'(f0));
    digit(0, 0, 1'b1, 6);
    idle(4);
    check("pattern_then_frame", 32'(o_value), 32'h3210);

    // Reset mid-frame discards digits 0-2.
    digit(0, 4, 1'b0, 6); digit(1, 5, 1'b0, 6); digit(2, 6, 1'b0, 6);
    idle(2);
    f0 = frames_seen;
    do_reset();
    digit(3, 7, 1'b0, 6);
    idle(4);
    check("reset_no_frame", 32'(frames_seen), 32'(f0));
    digit(0, 8, 1'b0, 6); digit(1, 9, 1'b0, 6); digit(2, 10, 1'b0, 6); digit(3, 11, 1'b0, 6);
    idle(4);
    check("reset_fresh_frame", 32'(frames_seen), 32'(f0 + 1));

    // Randomized scanning.
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 99);
      if (kind < 70) begin
        int k, r;
        logic [7:0] p;
        k = $urandom_range(0, 3);
        r = $urandom_range(0, 99);
        if (r < 80) p = ~{1'($urandom_range(0, 1)), seg_tab[$urandom_range(0, 15)]};
        else if (r < 90) p = {1'($urandom_range(0, 1)), 7'h7F};
        else p = 8'($urandom);
        drive(~(4'b0001 << k), p, $urandom_range(1, 8));
      end else if (kind < 80) begin
        logic [3:0] s;
        s = 4'($urandom);
        while (s inside {4'hF, 4'b1110, 4'b1101, 4'b1011, 4'b0111}) s = 4'($urandom);
        drive(s, 8'($urandom), $urandom_range(1, 2));
      end else begin
        idle($urandom_range(1, 3));
      end
    end

    idle(10);
    check("pending_frames", 32'(exp_q.size()), 32'd0);
    check("pattern_err_count", 32'(perr_seen), 32'(perr_exp));
    check("select_err_count", 32'(serr_seen), 32'(serr_exp));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
